// File: rtl/mo_linebuf_pkg.sv
// Shared definitions for the motion-object line-buffer controller.
//  LB_XW / LB_PW / LB_TRANSP : default X width, pixel width, transparent code
//  wr_state_t : write-side read-modify-write states
//  rd_state_t : scan-out / clear-behind-beam states
//  bank_t     : bank-select encoding (value of wr_bank)
package mo_linebuf_pkg;

    localparam int LB_XW     = 8;
    localparam int LB_PW     = 4;
    localparam int LB_TRANSP = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CHK  = 2'd1,
        WR   = 2'd2
    } wr_state_t;

    typedef enum logic {
        RD  = 1'b0,
        CLR = 1'b1
    } rd_state_t;

    typedef enum logic {
        BANK0 = 1'b0,
        BANK1 = 1'b1
    } bank_t;

    function automatic bank_t other_bank(input bank_t b);
        return (b == BANK0) ? BANK1 : BANK0;
    endfunction

endpackage

// File: rtl/mo_lb_port_mux.sv
// Two-bank port steering for the line-buffer RAMs.
//  clk, reset_n        : clock, asynchronous active-low reset
//  wr_bank_reg         : bank currently owned by the write FSM (selects read-data return)
//  wr_bank_next        : bank the write FSM owns next clock (selects registered port values)
//  wr_*_next/rd_*_next : next-clock address / data / write strobe from each FSM
//  bank_a/i/w_n        : registered RAM port outputs, index = bank number
//  bank_d              : RAM read data, index = bank number
//  wr_d / rd_d         : read data returned to the write FSM / read FSM
module mo_lb_port_mux
    import mo_linebuf_pkg::*;
#(
    parameter int XW = LB_XW,
    parameter int PW = LB_PW
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  bank_t                wr_bank_reg,
    input  bank_t                wr_bank_next,
    input  logic [XW-1:0]        wr_a_next,
    input  logic [PW-1:0]        wr_i_next,
    input  logic                 wr_w_n_next,
    input  logic [XW-1:0]        rd_a_next,
    input  logic [PW-1:0]        rd_i_next,
    input  logic                 rd_w_n_next,
    output logic [1:0][XW-1:0]   bank_a,
    output logic [1:0][PW-1:0]   bank_i,
    output logic [1:0]           bank_w_n,
    input  logic [1:0][PW-1:0]   bank_d,
    output logic [PW-1:0]        wr_d,
    output logic [PW-1:0]        rd_d
);

    // Steering happens before the register stage, keyed by the next owner,
    // so every RAM pin comes straight off a flop and a swap cannot glitch a strobe.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            localparam bank_t OWN = (gi == 0) ? BANK0 : BANK1;
            logic [XW-1:0] a_reg;
            logic [PW-1:0] i_reg;
            logic          w_n_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    a_reg   <= '0;
                    i_reg   <= '0;
                    w_n_reg <= 1'b1;
                end else if (wr_bank_next == OWN) begin
                    a_reg   <= wr_a_next;
                    i_reg   <= wr_i_next;
                    w_n_reg <= wr_w_n_next;
                end else begin
                    a_reg   <= rd_a_next;
                    i_reg   <= rd_i_next;
                    w_n_reg <= rd_w_n_next;
                end
            end

            assign bank_a[gi]   = a_reg;
            assign bank_i[gi]   = i_reg;
            assign bank_w_n[gi] = w_n_reg;
        end
    endgenerate

    assign wr_d = (wr_bank_reg == BANK0) ? bank_d[0] : bank_d[1];
    assign rd_d = (wr_bank_reg == BANK0) ? bank_d[1] : bank_d[0];

endmodule

// File: rtl/mo_linebuf_ctrl.sv
// Ping-pong controller for the two motion-object line-buffer RAMs.
// One bank collects the next scanline (first opaque pixel per X wins, via
// read-modify-write); the other is scanned to video and cleared behind the beam.
//  clk, reset_n              : clock, asynchronous active-low reset
//  line_start                : swap pulse at start of hblank
//  wr_valid/wr_ready/wr_x/wr_pix : pixel write handshake from the MO generator
//  pix_en / pix_out          : video pixel strobe / registered video pixel
//  bankN_a/i/w_n/d           : RAM ports for bank 0 and bank 1
module mo_linebuf_ctrl
    import mo_linebuf_pkg::*;
#(
    parameter int            XW     = LB_XW,
    parameter int            PW     = LB_PW,
    parameter logic [PW-1:0] TRANSP = PW'(LB_TRANSP)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          line_start,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [XW-1:0] wr_x,
    input  logic [PW-1:0] wr_pix,
    input  logic          pix_en,
    output logic [PW-1:0] pix_out,
    output logic [XW-1:0] bank0_a,
    output logic [PW-1:0] bank0_i,
    output logic          bank0_w_n,
    input  logic [PW-1:0] bank0_d,
    output logic [XW-1:0] bank1_a,
    output logic [PW-1:0] bank1_i,
    output logic          bank1_w_n,
    input  logic [PW-1:0] bank1_d
);

    wr_state_t     wr_state_reg, wr_state_next;
    rd_state_t     rd_state_reg, rd_state_next;
    bank_t         wr_bank_reg,  wr_bank_next;
    logic [XW-1:0] x_reg,        x_next;
    logic [PW-1:0] pix_reg,      pix_next;
    logic [XW-1:0] rd_x_reg,     rd_x_next;
    logic [PW-1:0] pix_out_reg,  pix_out_next;
    logic          ready_en_reg;

    logic [XW-1:0] wr_a_next, rd_a_next;
    logic [PW-1:0] wr_i_next;
    logic          wr_w_n_next, rd_w_n_next;
    logic [PW-1:0] wr_d, rd_d;

    logic [1:0][XW-1:0] bank_a;
    logic [1:0][PW-1:0] bank_i;
    logic [1:0]         bank_w_n;
    logic [1:0][PW-1:0] bank_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_state_reg <= IDLE;
            rd_state_reg <= RD;
            wr_bank_reg  <= BANK0;
            x_reg        <= '0;
            pix_reg      <= TRANSP;
            rd_x_reg     <= '0;
            pix_out_reg  <= TRANSP;
            ready_en_reg <= 1'b0;
        end else begin
            wr_state_reg <= wr_state_next;
            rd_state_reg <= rd_state_next;
            wr_bank_reg  <= wr_bank_next;
            x_reg        <= x_next;
            pix_reg      <= pix_next;
            rd_x_reg     <= rd_x_next;
            pix_out_reg  <= pix_out_next;
            ready_en_reg <= 1'b1;
        end
    end

    always_comb begin
        wr_state_next = wr_state_reg;
        rd_state_next = rd_state_reg;
        wr_bank_next  = wr_bank_reg;
        x_next        = x_reg;
        pix_next      = pix_reg;
        rd_x_next     = rd_x_reg;
        pix_out_next  = pix_out_reg;
        wr_a_next     = x_reg;
        wr_i_next     = TRANSP;
        wr_w_n_next   = 1'b1;
        rd_w_n_next   = 1'b1;
        // ready_en_reg keeps wr_ready low until the first clock out of reset;
        // line_start blocks acceptance because the bank is changing under us.
        wr_ready = ready_en_reg && (wr_state_reg == IDLE) && !line_start;

        if (line_start) begin
            // Swap dominates everything: a pending RMW is dropped without writing.
            wr_bank_next  = other_bank(wr_bank_reg);
            wr_state_next = IDLE;
            rd_state_next = RD;
            rd_x_next     = '0;
        end else begin
            case (wr_state_reg)
                IDLE: begin
                    if (wr_valid && wr_ready) begin
                        x_next    = wr_x;
                        pix_next  = wr_pix;
                        wr_a_next = wr_x;
                        if (wr_pix != TRANSP) begin
                            wr_state_next = CHK;
                        end
                    end
                end
                CHK: begin
                    // Only an empty slot may be filled: earlier objects have priority.
                    if (wr_d == TRANSP) begin
                        wr_state_next = WR;
                        wr_i_next     = pix_reg;
                        wr_w_n_next   = 1'b0;
                    end else begin
                        wr_state_next = IDLE;
                    end
                end
                default: wr_state_next = IDLE;
            endcase

            case (rd_state_reg)
                RD: begin
                    if (pix_en) begin
                        pix_out_next  = rd_d;
                        rd_state_next = CLR;
                        rd_w_n_next   = 1'b0;
                    end
                end
                CLR: begin
                    rd_x_next     = rd_x_reg + XW'(1);
                    rd_state_next = RD;
                end
            endcase
        end
        rd_a_next = rd_x_next;
    end

    mo_lb_port_mux #(
        .XW (XW),
        .PW (PW)
    ) u_port_mux (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_bank_reg  (wr_bank_reg),
        .wr_bank_next (wr_bank_next),
        .wr_a_next    (wr_a_next),
        .wr_i_next    (wr_i_next),
        .wr_w_n_next  (wr_w_n_next),
        .rd_a_next    (rd_a_next),
        .rd_i_next    (TRANSP),
        .rd_w_n_next  (rd_w_n_next),
        .bank_a       (bank_a),
        .bank_i       (bank_i),
        .bank_w_n     (bank_w_n),
        .bank_d       (bank_d),
        .wr_d         (wr_d),
        .rd_d         (rd_d)
    );

    assign bank_d[0] = bank0_d;
    assign bank_d[1] = bank1_d;
    assign bank0_a   = bank_a[0];
    assign bank0_i   = bank_i[0];
    assign bank0_w_n = bank_w_n[0];
    assign bank1_a   = bank_a[1];
    assign bank1_i   = bank_i[1];
    assign bank1_w_n = bank_w_n[1];
    assign pix_out   = pix_out_reg;

endmodule
